uart_rx_deserializer: RTL and testbench
=======================================

UART_RX_DESERIALIZER -- requirements
Module: uart_rx_deserializer

Interface
REQ-001 Parameter CLKS_PER_BIT, default 16, clk cycles per UART bit; legal range 4..255.
REQ-002 Parameter PARITY_EN, default 0, 1 = one parity bit follows the data bits.
REQ-003 Parameter PARITY_ODD, default 0, 0 = even parity, 1 = odd parity; ignored when PARITY_EN=0.
REQ-004 Port clk  in  1  sole clock; all state updates on its rising edge.
REQ-005 Port reset  in  1  synchronous, active-high reset.
REQ-006 Port rxd  in  1  serial input, asynchronous to clk, idle high.
REQ-007 Port io_data  out  8  received byte, LSB received first.
REQ-008 Port io_valid  out  1  io_data holds an undelivered byte.
REQ-009 Port io_ready  in  1  consumer accepts io_data when io_valid && io_ready.
REQ-010 Port io_frameError  out  1  one-cycle pulse, stop bit sampled low.
REQ-011 Port io_parityError  out  1  one-cycle pulse, parity mismatch.
REQ-012 Port io_overrun  out  1  one-cycle pulse, completed byte dropped because the buffer was full.
REQ-013 Port io_busy  out  1  high in every FSM state except IDLE.

Function
REQ-014 rxd SHALL pass through a 2-flop synchronizer; all logic uses the synchronized value rxs.
REQ-015 FSM states SHALL be IDLE, START, DATA, PARITY, STOP, WAIT_IDLE.
REQ-016 IDLE: rxs==0 -> START with bit counter cleared.
REQ-017 START: at count CLKS_PER_BIT/2-1, sample rxs; 1 -> IDLE (false start, no output); 0 -> DATA.
REQ-018 DATA: sample one bit every CLKS_PER_BIT cycles into shift register, LSB first; after bit 7 go to PARITY if PARITY_EN, else STOP.
REQ-019 PARITY: sample after CLKS_PER_BIT cycles; mismatch sets an internal error flag; then STOP.
REQ-020 STOP: sample after CLKS_PER_BIT cycles; 0 -> pulse io_frameError, discard byte, go WAIT_IDLE; 1 with parity flag set -> pulse io_parityError, discard byte, go IDLE; 1 otherwise -> deliver byte, go IDLE.
REQ-021 WAIT_IDLE: remain until rxs==1, then IDLE (break/line-low handling, no repeat errors).
REQ-022 Delivery: io_data loaded and io_valid high on the cycle after the stop-bit sample.
REQ-023 Stop sample occurs CLKS_PER_BIT/2 + (9+PARITY_EN)*CLKS_PER_BIT - 1 cycles after the first cycle of START.
REQ-024 io_valid SHALL stay high and io_data stable until a cycle with io_ready==1; io_valid clears on the following edge.
REQ-025 Delivery while io_valid && !io_ready: new byte dropped, io_overrun pulses, old byte retained.
REQ-026 Delivery in the same cycle as a handshake: new byte loaded, io_valid stays high, no overrun.
REQ-027 Bit counter width SHALL be ceil(log2(CLKS_PER_BIT)) bits; it never wraps mid-bit.
REQ-028 Only one error pulse of any kind per frame.

Reset
REQ-029 While reset is high: FSM=IDLE, counters=0, shift register=0, synchronizer flops=1.
REQ-030 While reset is high: io_data=0, io_valid=0, io_frameError=0, io_parityError=0, io_overrun=0, io_busy=0.
REQ-031 A reset mid-frame SHALL abandon the frame with no output or error pulse; reception restarts on the next falling edge after reset deasserts.

Structure
REQ-032 The shared package uart_pkg SHALL hold the FSM state enumeration and the CLKS_PER_BIT default constant.
REQ-033 The 2-flop synchronizer SHALL be a sub-module named uart_rx_sync with reset value 1.

Verification (CLKS_PER_BIT=16, PARITY_EN=0 unless stated)
REQ-034 Frame 0xA5 with io_ready=1 -> one io_valid cycle with io_data=0xA5, no error pulses.
REQ-035 rxd low for 4 cycles, then high -> no io_valid, no error pulse, FSM back in IDLE.
REQ-036 Frame 0x3C with stop bit low, rxd held low 40 more bit times -> exactly one io_frameError, no io_valid, no further pulses until rxd returns high.
REQ-037 Frames 0x11 then 0x22 with io_ready=0 -> io_overrun pulses once, io_data remains 0x11; io_ready=1 -> 0x11 accepted, io_valid clears.
REQ-038 PARITY_EN=1, PARITY_ODD=0, frame 0x07 sent with parity bit 0 -> io_parityError pulse, no io_valid.
REQ-039 Reset asserted during data bit 4 of frame 0xFF, then frame 0x5A -> no output for the first frame, io_data=0x5A for the second.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

  localparam int unsigned CLKS_PER_BIT_DEFAULT = 16;
  localparam int unsigned DATA_BITS            = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_IDLE
  } rx_state_e;

  // Expected parity bit for a data byte: even parity when odd == 0.
  function automatic logic parity_bit(input logic [DATA_BITS-1:0] d, input logic odd);
    return (^d) ^ odd;
  endfunction

endpackage

// File: rtl/uart_rx_deserializer_if.sv
// Byte-out stream plus status pulses between the UART receiver and its consumer.
interface uart_rx_deserializer_if;

  logic [uart_pkg::DATA_BITS-1:0] io_data;
  logic                           io_valid;
  logic                           io_ready;
  logic                           io_frameError;
  logic                           io_parityError;
  logic                           io_overrun;
  logic                           io_busy;

  modport master (
    output io_data, io_valid, io_frameError, io_parityError, io_overrun, io_busy,
    input  io_ready
  );

  modport slave (
    input  io_data, io_valid, io_frameError, io_parityError, io_overrun, io_busy,
    output io_ready
  );

endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line; resets to the idle (high) level.
module uart_rx_sync (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);

  logic [1:0] sync_q;

  always_ff @(posedge clk) begin
    if (reset) sync_q <= 2'b11;
    else       sync_q <= {sync_q[0], d_i};
  end

  assign q_o = sync_q[1];

endmodule

// File: rtl/uart_rx_deserializer.sv
// UART receiver: mid-bit sampling of 8 data bits (optional parity), one-entry output buffer.
module uart_rx_deserializer
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
  parameter bit          PARITY_EN    = 1'b0,
  parameter bit          PARITY_ODD   = 1'b0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   rxd,
  uart_rx_deserializer_if.master io
);

  localparam int unsigned    CW        = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0]  HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0]  BIT_LAST  = CW'(CLKS_PER_BIT - 1);

  logic                 rxs;
  rx_state_e            state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2:0]           bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_err_q, par_err_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 fe_q, fe_d;
  logic                 pe_q, pe_d;
  logic                 ov_q, ov_d;
  logic                 busy_q, busy_d;
  logic                 deliver;

  uart_rx_sync u_sync (
    .clk   (clk),
    .reset (reset),
    .d_i   (rxd),
    .q_o   (rxs)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      par_err_q <= 1'b0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      fe_q      <= 1'b0;
      pe_q      <= 1'b0;
      ov_q      <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      par_err_q <= par_err_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      fe_q      <= fe_d;
      pe_q      <= pe_d;
      ov_q      <= ov_d;
      busy_q    <= busy_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + CW'(1);
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    par_err_d = par_err_q;
    data_d    = data_q;
    valid_d   = valid_q && !io.io_ready;
    fe_d      = 1'b0;
    pe_d      = 1'b0;
    ov_d      = 1'b0;
    deliver   = 1'b0;

    unique case (state_q)
      IDLE: begin
        cnt_d     = '0;
        bit_idx_d = '0;
        par_err_d = 1'b0;
        if (!rxs) state_d = START;
      end
      START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d   = '0;
          state_d = rxs ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d     = '0;
          shift_d   = {rxs, shift_q[DATA_BITS-1:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) state_d = PARITY_EN ? PARITY : STOP;
        end
      end
      PARITY: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d     = '0;
          par_err_d = (rxs != parity_bit(shift_q, PARITY_ODD));
          state_d   = STOP;
        end
      end
      STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          if (!rxs) begin
            fe_d    = 1'b1;
            state_d = WAIT_IDLE;
          end else if (par_err_q) begin
            pe_d    = 1'b1;
            state_d = IDLE;
          end else begin
            deliver = 1'b1;
            state_d = IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        // A held-low line (break) produces one frame error, then waits here silently.
        cnt_d = '0;
        if (rxs) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A full buffer that is not being drained this cycle drops the new byte.
    if (deliver) begin
      if (valid_q && !io.io_ready) begin
        ov_d = 1'b1;
      end else begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end
    end

    busy_d = (state_d != IDLE);
  end

  assign io.io_data        = data_q;
  assign io.io_valid       = valid_q;
  assign io.io_frameError  = fe_q;
  assign io.io_parityError = pe_q;
  assign io.io_overrun     = ov_q;
  assign io.io_busy        = busy_q;

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Self-checking bench: 8N1 receiver (dut0) and 8E1 receiver (dut1) driven with serial frames.
module tb_uart_rx_deserializer;
  timeunit 1ns;
  timeprecision 1ps;

  localparam int unsigned CPB = 16;

  logic clk = 1'b0;
  logic reset;
  logic rxd0, rxd1;
  logic ready_man;
  logic rnd_ready = 1'b1;
  logic rand_en;
  int unsigned cyc = 0;

  uart_rx_deserializer_if if0 ();
  uart_rx_deserializer_if if1 ();

  assign if0.io_ready = rand_en ? rnd_ready : ready_man;
  assign if1.io_ready = 1'b1;

  uart_rx_deserializer #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b0), .PARITY_ODD(1'b0)) u_dut0 (
    .clk   (clk),
    .reset (reset),
    .rxd   (rxd0),
    .io    (if0.master)
  );

  uart_rx_deserializer #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) u_dut1 (
    .clk   (clk),
    .reset (reset),
    .rxd   (rxd1),
    .io    (if1.master)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) rnd_ready <= ($urandom_range(3) != 0);

  // Event counters observed on the falling edge, away from DUT updates.
  int fe0 = 0, pe0 = 0, ov0 = 0, vc0 = 0;
  int fe1 = 0, pe1 = 0, ov1 = 0;
  logic [7:0] hs0[$];
  logic [7:0] hs1[$];
  int unsigned rise0[$];
  logic pv0 = 1'b0;

  always @(negedge clk) begin
    if (!reset) begin
      if (if0.io_frameError)  fe0 <= fe0 + 1;
      if (if0.io_parityError) pe0 <= pe0 + 1;
      if (if0.io_overrun)     ov0 <= ov0 + 1;
      if (if0.io_valid)       vc0 <= vc0 + 1;
      if (if0.io_valid && if0.io_ready) hs0.push_back(if0.io_data);
      if (if0.io_valid && !pv0) rise0.push_back(cyc);
      pv0 <= if0.io_valid;
      if (if1.io_frameError)  fe1 <= fe1 + 1;
      if (if1.io_parityError) pe1 <= pe1 + 1;
      if (if1.io_overrun)     ov1 <= ov1 + 1;
      if (if1.io_valid && if1.io_ready) hs1.push_back(if1.io_data);
    end else begin
      pv0 <= 1'b0;
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input bit which, input logic v);
    if (which) rxd1 = v;
    else       rxd0 = v;
    tick(CPB);
  endtask

  task automatic send_frame(input bit which, input logic [7:0] d, input bit par_en,
                            input logic par, input logic stop);
    send_bit(which, 1'b0);
    for (int i = 0; i < 8; i++) send_bit(which, d[i]);
    if (par_en) send_bit(which, par);
    send_bit(which, stop);
  endtask

  function automatic int last_hs0();
    return (hs0.size() > 0) ? int'(hs0[hs0.size()-1]) : 32'hDEAD;
  endfunction

  function automatic int last_hs1();
    return (hs1.size() > 0) ? int'(hs1[hs1.size()-1]) : 32'hDEAD;
  endfunction

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         hold_bits;
    int         exp_hs;
    int         exp_fe;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int b_fe, b_pe, b_ov, b_hs, b_vc, b_pe1, b_hs1, b_fe1;
    int unsigned c0;
    logic [7:0] exp_q[$];
    int nfe;

    vecs[0] = '{8'hA5, 1'b1, 0,  1, 0};
    vecs[1] = '{8'h00, 1'b1, 0,  1, 0};
    vecs[2] = '{8'hFF, 1'b1, 0,  1, 0};
    vecs[3] = '{8'h3C, 1'b0, 40, 0, 1};
    vecs[4] = '{8'h81, 1'b1, 0,  1, 0};

    reset = 1'b1; rxd0 = 1'b0; rxd1 = 1'b0; ready_man = 1'b1; rand_en = 1'b0;
    tick(5);
    chk("rst_valid0", int'(32'(if0.io_valid)), 0);
    chk("rst_data0",  int'(32'(if0.io_data)), 0);
    chk("rst_busy0",  int'(32'(if0.io_busy)), 0);
    chk("rst_fe0",    int'(32'(if0.io_frameError)), 0);
    chk("rst_ov0",    int'(32'(if0.io_overrun)), 0);
    chk("rst_busy1",  int'(32'(if1.io_busy)), 0);
    chk("rst_pe1",    int'(32'(if1.io_parityError)), 0);
    rxd0 = 1'b1; rxd1 = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(4);
    chk("idle_busy0", int'(32'(if0.io_busy)), 0);

    // Table-driven frames on the 8N1 receiver with the consumer always ready.
    for (int i = 0; i < 5; i++) begin
      b_fe = fe0; b_pe = pe0; b_ov = ov0; b_hs = hs0.size(); b_vc = vc0;
      c0 = cyc;
      send_frame(1'b0, vecs[i].data, 1'b0, 1'b0, vecs[i].stop);
      if (vecs[i].hold_bits > 0) begin
        tick(CPB * vecs[i].hold_bits);
        chk($sformatf("v%0d_fe_in_break", i), fe0 - b_fe, 1);
        chk($sformatf("v%0d_busy_in_break", i), int'(32'(if0.io_busy)), 1);
      end
      rxd0 = 1'b1;
      tick(3 * CPB);
      chk($sformatf("v%0d_handshakes", i), hs0.size() - b_hs, vecs[i].exp_hs);
      chk($sformatf("v%0d_valid_cycles", i), vc0 - b_vc, vecs[i].exp_hs);
      chk($sformatf("v%0d_frame_err", i), fe0 - b_fe, vecs[i].exp_fe);
      chk($sformatf("v%0d_parity_err", i), pe0 - b_pe, 0);
      chk($sformatf("v%0d_overrun", i), ov0 - b_ov, 0);
      chk($sformatf("v%0d_busy_end", i), int'(32'(if0.io_busy)), 0);
      if (vecs[i].exp_hs != 0) chk($sformatf("v%0d_data", i), last_hs0(), int'(32'(vecs[i].data)));
      if (i == 0)
        chk("v0_latency", (rise0.size() > 0) ? int'(rise0[rise0.size()-1] - c0) : -1,
            int'(3 + CPB / 2 + 9 * CPB));
    end

    // False start: a 4-cycle low glitch is rejected at the half-bit sample.
    b_fe = fe0; b_hs = hs0.size(); b_vc = vc0;
    rxd0 = 1'b0;
    tick(4);
    chk("glitch_busy_high", int'(32'(if0.io_busy)), 1);
    rxd0 = 1'b1;
    tick(2 * CPB);
    chk("glitch_busy_low", int'(32'(if0.io_busy)), 0);
    chk("glitch_valid", vc0 - b_vc, 0);
    chk("glitch_fe", fe0 - b_fe, 0);

    // Overrun: two frames with no consumer, first byte must survive.
    ready_man = 1'b0;
    b_ov = ov0; b_hs = hs0.size();
    send_frame(1'b0, 8'h11, 1'b0, 1'b0, 1'b1);
    tick(CPB);
    chk("ovr_first_valid", int'(32'(if0.io_valid)), 1);
    chk("ovr_first_data", int'(32'(if0.io_data)), 8'h11);
    send_frame(1'b0, 8'h22, 1'b0, 1'b0, 1'b1);
    tick(2 * CPB);
    chk("ovr_pulses", ov0 - b_ov, 1);
    chk("ovr_valid_held", int'(32'(if0.io_valid)), 1);
    chk("ovr_data_held", int'(32'(if0.io_data)), 8'h11);
    chk("ovr_no_hs", hs0.size() - b_hs, 0);
    ready_man = 1'b1;
    tick(1);
    chk("ovr_accept_hs", hs0.size() - b_hs, 1);
    chk("ovr_accept_data", last_hs0(), 8'h11);
    chk("ovr_valid_clear", int'(32'(if0.io_valid)), 0);

    // Even parity receiver: 0x07 has three ones, so the correct parity bit is 1.
    b_pe1 = pe1; b_hs1 = hs1.size(); b_fe1 = fe1;
    send_frame(1'b1, 8'h07, 1'b1, 1'b0, 1'b1);
    tick(2 * CPB);
    chk("par_bad_pulse", pe1 - b_pe1, 1);
    chk("par_bad_no_hs", hs1.size() - b_hs1, 0);
    chk("par_bad_valid", int'(32'(if1.io_valid)), 0);
    send_frame(1'b1, 8'h07, 1'b1, 1'b1, 1'b1);
    tick(2 * CPB);
    chk("par_good_hs", hs1.size() - b_hs1, 1);
    chk("par_good_data", last_hs1(), 8'h07);
    send_frame(1'b1, 8'hC3, 1'b1, ^(8'hC3), 1'b1);
    tick(2 * CPB);
    chk("par_good2_data", last_hs1(), 8'hC3);
    chk("par_total_pe", pe1 - b_pe1, 1);
    chk("par_total_fe", fe1 - b_fe1, 0);

    // Reset during data bit 4 of 0xFF abandons the frame silently.
    b_fe = fe0; b_pe = pe0; b_ov = ov0; b_hs = hs0.size(); b_vc = vc0;
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b0, 1'b1);
    tick(CPB / 2);
    chk("midrst_busy_before", int'(32'(if0.io_busy)), 1);
    reset = 1'b1;
    tick(3);
    chk("midrst_busy_in_reset", int'(32'(if0.io_busy)), 0);
    reset = 1'b0;
    tick(10 * CPB);
    chk("midrst_no_valid", vc0 - b_vc, 0);
    chk("midrst_no_err", (fe0 - b_fe) + (pe0 - b_pe) + (ov0 - b_ov), 0);
    send_frame(1'b0, 8'h5A, 1'b0, 1'b0, 1'b1);
    tick(2 * CPB);
    chk("midrst_next_hs", hs0.size() - b_hs, 1);
    chk("midrst_next_data", last_hs0(), 8'h5A);

    // Random frames with a randomly stalling consumer against a per-frame outcome model.
    rand_en = 1'b1;
    b_fe = fe0; b_pe = pe0; b_ov = ov0; b_hs = hs0.size();
    nfe = 0;
    for (int f = 0; f < 30; f++) begin
      logic [7:0] d;
      logic st;
      d  = 8'($urandom_range(255));
      st = ($urandom_range(5) != 0);
      send_frame(1'b0, d, 1'b0, 1'b0, st);
      rxd0 = 1'b1;
      tick(CPB * $urandom_range(1, 3));
      if (st) exp_q.push_back(d);
      else    nfe++;
    end
    tick(3 * CPB);
    rand_en = 1'b0;
    chk("rnd_count", hs0.size() - b_hs, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      chk($sformatf("rnd_byte%0d", i),
          (b_hs + i < hs0.size()) ? int'(hs0[b_hs + i]) : 32'hDEAD, int'(exp_q[i]));
    chk("rnd_fe", fe0 - b_fe, nfe);
    chk("rnd_ov", ov0 - b_ov, 0);
    chk("rnd_pe", pe0 - b_pe, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
